s3g_tx_stream: RTL and testbench
================================

Name: s3g_tx_stream

Overview:
Streaming S3G packet transmitter for reply payloads longer than the 16-byte register-file transmitter can carry; it is the transmit-side counterpart of the receiver's buffer read port. Payload bytes are fetched from a synchronous byte buffer via an address/data read port. The block frames them as 0xD5, length, payload, CRC8, and writes each byte to the shared UART transmitters through the tx_data/tx_wr path. It sits between the command executor (which fills the buffer and pulses packet_wr) and the two uart_transceiver instances.

Parameters:
START_BYTE, 8'hD5, frame start byte.
ADDR_W, 8, buffer address width; payload length is ≤ 2^ADDR_W-1 and ≤ 255.
TIMEOUT_CYCLES, 50000, tx_done watchdog limit; used only with S3G_TX_STREAM_TIMEOUT_EN.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous assert, active low.
packet_wr  in  1  one-cycle start strobe; sampled only when busy=0.
payload_len  in  8  payload byte count, latched on accepted packet_wr.
busy  out  1  high from accepted packet_wr until the packet completes.
done  out  1  one-cycle pulse after the CRC byte is acknowledged.
error  out  1  one-cycle pulse on watchdog abort; tied 0 without the macro.
buffer_addr  out  ADDR_W  payload read address.
buffer_data  in  8  payload byte; valid 1 cycle after buffer_addr changes.
tx_data  out  8  byte to the UARTs; held stable until the next tx_wr.
tx_wr  out  1  one-cycle write strobe to both UARTs.
tx1_done  in  1  UART1 byte-complete pulse.
tx2_done  in  1  UART2 byte-complete pulse.

Behaviour:
- Reset values: busy=0, done=0, error=0, tx_wr=0, tx_data=0, buffer_addr=0, crc=0, FSM=IDLE. Reset mid-packet aborts immediately; no done pulse is issued.
- Acknowledge: sticky flags d1/d2 are cleared in the cycle tx_wr=1 and set by tx1_done/tx2_done. A byte is complete when d1&d2. A done pulse coincident with tx_wr is credited to the new byte.
- States and transitions:
  - IDLE: on packet_wr, latch len, set crc=0, set buffer_addr=0, set busy=1, go to START. packet_wr while busy is ignored.
  - START: tx_data=START_BYTE, tx_wr=1, go to WAIT_S. The first tx_wr occurs 1 cycle after the accepted packet_wr.
  - WAIT_S: on ack, go to LEN.
  - LEN: tx_data=len, tx_wr=1, go to WAIT_L.
  - WAIT_L: on ack, go to FETCH if len≠0, else CRC.
  - FETCH: buffer_addr is already valid; wait 1 cycle for buffer_data, then go to PAYLOAD.
  - PAYLOAD: tx_data=buffer_data, tx_wr=1, crc=crc8(crc,buffer_data), buffer_addr+=1, remaining-=1, go to WAIT_P.
  - WAIT_P: on ack, go to FETCH if remaining≠0, else CRC.
  - CRC: tx_data=crc, tx_wr=1, go to WAIT_C.
  - WAIT_C: on ack, set done=1, busy=0, go to IDLE. packet_wr is accepted again the next cycle.
- CRC8 is Dallas/Maxim: reflected polynomial 0x8C, init 0x00, no final XOR, LSB first. It is computed combinationally over 8 bits in one cycle, over payload bytes only (the start and length bytes are excluded).
- len=0 gives the frame D5 00 00.
- buffer_addr wraps modulo 2^ADDR_W. With len=255 and ADDR_W=8 it ends at 0xFF, so no wrap occurs.
- tx_wr is never asserted twice without an intervening ack.

Optional Feature:
S3G_TX_STREAM_TIMEOUT_EN:
- Defined: a counter runs in every WAIT_* state and resets on each tx_wr.
- If the counter reaches TIMEOUT_CYCLES before ack, the block pulses error=1 for 1 cycle, forces busy=0, returns to IDLE, and does not pulse done.
- Undefined: the counter logic is absent, error is tied 0, and the block waits indefinitely for ack.

Test Plan:
- len=1, buf[0]=0x01, both dones 20 cycles after each tx_wr -> tx_data sequence D5,01,01,5E; exactly 4 tx_wr; done 1 cycle after the 4th ack; busy low afterwards.
- len=9, buf="123456789" (0x31..0x39) -> frame D5,09,31..39,A1; buffer_addr steps 0..8.
- len=0 -> D5,00,00; buffer_addr stays 0.
- tx1_done at +5 and tx2_done at +30 after each tx_wr -> next tx_wr no earlier than 1 cycle after tx2_done; a second packet_wr while busy does not change the frame.
- Reset asserted after the LEN byte -> busy, tx_wr and buffer_addr are 0 asynchronously; no done; a new packet after release is framed correctly.
- With the macro and TIMEOUT_CYCLES=100, tx2_done withheld -> error pulse 100 cycles after the stalled tx_wr; busy=0; no done.

Source files
------------

// File: rtl/s3g_tx_stream.sv
// -----------------------------------------------------------------------------
// s3g_tx_stream
// Streaming S3G packet transmitter. A packet is started by a one-cycle
// packet_wr strobe. The block sends 0xD5 (START_BYTE), then the payload
// length, then the payload bytes fetched from a synchronous byte buffer, then
// a Dallas/Maxim CRC8 over the payload bytes only. Each byte is handed to both
// UART transmitters with a one-cycle tx_wr strobe. The next byte is not
// issued until both transmitters have reported byte completion.
//
// Optional feature macro: S3G_TX_STREAM_TIMEOUT_EN
//   Defined   : a watchdog aborts the packet (error pulse, no done pulse) if
//               an acknowledge takes TIMEOUT_CYCLES cycles.
//   Undefined : no watchdog, error is tied low, acknowledges are awaited
//               indefinitely.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   packet_wr    start strobe, honoured only while busy is low
//   payload_len  payload byte count, latched on an accepted packet_wr
//   busy         high from accepted packet_wr until the packet completes
//   done         one-cycle pulse after the CRC byte is acknowledged
//   error        one-cycle pulse on watchdog abort
//   buffer_addr  payload buffer read address
//   buffer_data  payload byte, valid one cycle after buffer_addr changes
//   tx_data      byte to the UARTs, stable until the next tx_wr
//   tx_wr        one-cycle write strobe to both UARTs
//   tx1_done     UART1 byte-complete pulse
//   tx2_done     UART2 byte-complete pulse
// -----------------------------------------------------------------------------
module s3g_tx_stream #(
    parameter logic [7:0] START_BYTE     = 8'hD5,
    parameter int         ADDR_W         = 8,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              packet_wr,
    input  logic [7:0]        payload_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] buffer_addr,
    input  logic [7:0]        buffer_data,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx1_done,
    input  logic              tx2_done
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_WAIT_S  = 4'd2,
        ST_LEN     = 4'd3,
        ST_WAIT_L  = 4'd4,
        ST_FETCH   = 4'd5,
        ST_PAYLOAD = 4'd6,
        ST_WAIT_P  = 4'd7,
        ST_CRC     = 4'd8,
        ST_WAIT_C  = 4'd9
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("s3g_tx_stream: TIMEOUT_CYCLES must be at least 2");
    end

    // Dallas/Maxim CRC8 (reflected poly 0x8C), one whole byte per call.
    // Folding the data byte in first and then shifting eight times is
    // equivalent to the bit-serial LSB-first form because the CRC is linear.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data_in);
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 8'h8C;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t              state_r, state_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic                tx_wr_r, tx_wr_nxt_s;
    logic [7:0]          tx_data_r, tx_data_nxt_s;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic [7:0]          crc_r, crc_nxt_s;
    logic [7:0]          len_r, len_nxt_s;
    logic [7:0]          rem_r, rem_nxt_s;
    logic                d1_r, d2_r;
    logic                ack_s;
    logic                in_wait_s;
    logic                timeout_s;

    // Flags are stale while tx_wr is high (they clear at that edge), so the
    // acknowledge is masked during the strobe cycle.
    assign ack_s     = d1_r & d2_r & ~tx_wr_r;
    assign in_wait_s = (state_r == ST_WAIT_S) || (state_r == ST_WAIT_L) ||
                       (state_r == ST_WAIT_P) || (state_r == ST_WAIT_C);

    assign busy        = busy_r;
    assign done        = done_r;
    assign tx_wr       = tx_wr_r;
    assign tx_data     = tx_data_r;
    assign buffer_addr = addr_r;

    // Sticky per-UART completion flags; a done pulse coincident with tx_wr
    // belongs to the byte being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r <= 1'b0;
            d2_r <= 1'b0;
        end else if (tx_wr_r) begin
            d1_r <= tx1_done;
            d2_r <= tx2_done;
        end else begin
            d1_r <= d1_r | tx1_done;
            d2_r <= d2_r | tx2_done;
        end
    end

`ifdef S3G_TX_STREAM_TIMEOUT_EN
    logic [31:0] wd_cnt_r;
    logic        error_r;

    // Watchdog: restarts on every byte strobe, counts while awaiting acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= 32'd0;
        end else if (tx_wr_r) begin
            wd_cnt_r <= 32'd1;
        end else if (in_wait_s) begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
        end else begin
            wd_cnt_r <= 32'd0;
        end
    end

    // Fires on the cycle the count reaches the limit so that error appears
    // exactly TIMEOUT_CYCLES cycles after the stalled strobe.
    assign timeout_s = in_wait_s && !tx_wr_r &&
                       (wd_cnt_r >= 32'(TIMEOUT_CYCLES - 1));

    // Error pulse register; an acknowledge in the same cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_r <= 1'b0;
        end else begin
            error_r <= timeout_s & ~ack_s;
        end
    end

    assign error = error_r;
`else
    assign timeout_s = 1'b0;
    assign error     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (packet_wr) state_nxt_s = ST_START;
                else           state_nxt_s = ST_IDLE;
            end
            ST_START:   state_nxt_s = ST_WAIT_S;
            ST_WAIT_S: begin
                if (ack_s)          state_nxt_s = ST_LEN;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_WAIT_S;
            end
            ST_LEN:     state_nxt_s = ST_WAIT_L;
            ST_WAIT_L: begin
                if (ack_s)          state_nxt_s = (len_r != 8'd0) ? ST_FETCH : ST_CRC;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_WAIT_L;
            end
            ST_FETCH:   state_nxt_s = ST_PAYLOAD;
            ST_PAYLOAD: state_nxt_s = ST_WAIT_P;
            ST_WAIT_P: begin
                if (ack_s)          state_nxt_s = (rem_r != 8'd0) ? ST_FETCH : ST_CRC;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_WAIT_P;
            end
            ST_CRC:     state_nxt_s = ST_WAIT_C;
            ST_WAIT_C: begin
                if (ack_s || timeout_s) state_nxt_s = ST_IDLE;
                else                    state_nxt_s = ST_WAIT_C;
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs and datapath.
    always_comb begin
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        tx_wr_nxt_s   = 1'b0;
        tx_data_nxt_s = tx_data_r;
        addr_nxt_s    = addr_r;
        crc_nxt_s     = crc_r;
        len_nxt_s     = len_r;
        rem_nxt_s     = rem_r;
        case (state_r)
            ST_IDLE: begin
                if (packet_wr) begin
                    len_nxt_s  = payload_len;
                    rem_nxt_s  = payload_len;
                    crc_nxt_s  = 8'h00;
                    addr_nxt_s = {ADDR_W{1'b0}};
                    busy_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_START: begin
                tx_data_nxt_s = START_BYTE;
                tx_wr_nxt_s   = 1'b1;
            end
            ST_LEN: begin
                tx_data_nxt_s = len_r;
                tx_wr_nxt_s   = 1'b1;
            end
            ST_PAYLOAD: begin
                tx_data_nxt_s = buffer_data;
                tx_wr_nxt_s   = 1'b1;
                crc_nxt_s     = crc8_byte(crc_r, buffer_data);
                addr_nxt_s    = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                rem_nxt_s     = rem_r - 8'd1;
            end
            ST_CRC: begin
                tx_data_nxt_s = crc_r;
                tx_wr_nxt_s   = 1'b1;
            end
            ST_WAIT_C: begin
                if (ack_s) begin
                    done_nxt_s = 1'b1;
                    busy_nxt_s = 1'b0;
                end else if (timeout_s) begin
                    busy_nxt_s = 1'b0;
                end else begin
                    busy_nxt_s = busy_r;
                end
            end
            ST_WAIT_S, ST_WAIT_L, ST_WAIT_P: begin
                if (timeout_s && !ack_s) begin
                    busy_nxt_s = 1'b0;
                end else begin
                    busy_nxt_s = busy_r;
                end
            end
            ST_FETCH: begin
                busy_nxt_s = busy_r;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            tx_wr_r   <= 1'b0;
            tx_data_r <= 8'h00;
            addr_r    <= {ADDR_W{1'b0}};
            crc_r     <= 8'h00;
            len_r     <= 8'h00;
            rem_r     <= 8'h00;
        end else begin
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            tx_wr_r   <= tx_wr_nxt_s;
            tx_data_r <= tx_data_nxt_s;
            addr_r    <= addr_nxt_s;
            crc_r     <= crc_nxt_s;
            len_r     <= len_nxt_s;
            rem_r     <= rem_nxt_s;
        end
    end

endmodule

// File: tb/tb_s3g_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_s3g_tx_stream
// Self-checking bench for s3g_tx_stream. A synchronous buffer model and a
// UART-completion responder surround the DUT; a monitor captures every byte
// strobed out and checks acknowledge ordering and done latency. Expected
// frames come from a queue-based model (start, length, payload, bit-serial
// CRC8). With S3G_TX_STREAM_TIMEOUT_EN defined the watchdog is exercised
// with a limit of 100 cycles.
// -----------------------------------------------------------------------------
module tb_s3g_tx_stream;

`ifdef S3G_TX_STREAM_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 50000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       packet_wr = 1'b0;
    logic [7:0] payload_len = 8'd0;
    logic       busy, done, error;
    logic [7:0] buffer_addr;
    logic [7:0] buffer_data = 8'd0;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx1_done = 1'b0;
    logic       tx2_done = 1'b0;

    s3g_tx_stream #(
        .START_BYTE     (8'hD5),
        .ADDR_W         (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .packet_wr   (packet_wr),
        .payload_len (payload_len),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .buffer_addr (buffer_addr),
        .buffer_data (buffer_data),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx1_done    (tx1_done),
        .tx2_done    (tx2_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] cap_q[$];
    int cyc = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int last_ack_cyc = 0, last_wr_cyc = 0;
    bit pending = 0, s1 = 0, s2 = 0;
    int dly1 = 4, dly2 = 4;
    bit withhold2 = 0;
    int c1 = 0, c2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous buffer: data follows the address one clock later.
    always @(posedge clk) buffer_data <= mem[buffer_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // UART responder: completion pulses dly1/dly2 cycles after each tx_wr.
    always @(negedge clk) begin
        tx1_done = 1'b0;
        tx2_done = 1'b0;
        if (!rst_n) begin
            c1 = 0; c2 = 0;
        end else if (tx_wr) begin
            c1 = dly1;
            c2 = withhold2 ? 0 : dly2;
        end else begin
            if (c1 > 0) begin c1--; if (c1 == 0) tx1_done = 1'b1; end
            if (c2 > 0) begin c2--; if (c2 == 0) tx2_done = 1'b1; end
        end
    end

    // Monitor: capture bytes, check ack-before-next-strobe and done timing.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            pending = 0; s1 = 0; s2 = 0;
        end else begin
            if (tx1_done) begin s1 = 1; last_ack_cyc = cyc; end
            if (tx2_done) begin s2 = 1; last_ack_cyc = cyc; end
            if (tx_wr) begin
                if (pending) check("ack_before_wr", {31'd0, s1 && s2}, 32'd1);
                pending = 1; s1 = 0; s2 = 0;
                cap_q.push_back(tx_data);
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                pending = 0;
                check("done_latency", {31'd0, (cyc - last_ack_cyc >= 1) && (cyc - last_ack_cyc <= 3)}, 32'd1);
                check("done_busy_low", {31'd0, busy}, 32'd0);
            end
            if (error) begin
                err_cnt++;
                pending = 0;
                check("error_latency", cyc - last_wr_cyc, TO);
                check("error_busy_low", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Reference CRC: bit-serial Dallas/Maxim, LSB first, over payload only.
    function automatic logic [7:0] model_crc(input int n);
        logic [7:0] crc = 8'h00;
        logic [7:0] b;
        logic fb;
        for (int i = 0; i < n; i++) begin
            b = mem[i];
            for (int k = 0; k < 8; k++) begin
                fb  = crc[0] ^ b[k];
                crc = crc >> 1;
                if (fb) crc = crc ^ 8'h8C;
            end
        end
        return crc;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < 256; i++) mem[i] = (i < n) ? 8'($urandom) : 8'h00;
    endtask

    // Issue packet_wr and check the first strobe timing.
    task automatic start_packet(input int len);
        @(negedge clk);
        packet_wr = 1'b1;
        payload_len = 8'(len);
        @(negedge clk);
        packet_wr = 1'b0;
        #2;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("no_wr_yet", {31'd0, tx_wr}, 32'd0);
        @(negedge clk);
        #2;
        check("first_wr", {31'd0, tx_wr}, 32'd1);
        check("first_byte", {24'd0, tx_data}, 32'hD5);
    endtask

    // Send one packet and compare the captured frame with the model.
    task automatic run_packet(input int len, input int da, input int db,
                              input bit dbl_wr, input int exp_crc);
        logic [7:0] exp_q[$];
        int d0, budget;
        exp_q = {};
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
        exp_q.push_back(model_crc(len));
        dly1 = da; dly2 = db;
        cap_q = {};
        d0 = done_cnt;
        budget = (len + 3) * ((da > db ? da : db) + 8) + 50;
        start_packet(len);
        for (int c = 0; c < budget && done_cnt == d0; c++) begin
            @(negedge clk);
            #2;
            if (dbl_wr && c == 40) begin packet_wr = 1'b1; payload_len = 8'(len ^ 8'h5A); end
            else packet_wr = 1'b0;
        end
        packet_wr = 1'b0;
        check("done_count", done_cnt - d0, 32'd1);
        check("frame_size", cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("byte%0d", i), {24'd0, cap_q[i]}, {24'd0, exp_q[i]});
        if (exp_crc >= 0 && cap_q.size() > 0)
            check("crc_literal", {24'd0, cap_q[cap_q.size()-1]}, exp_crc);
        check("addr_end", {24'd0, buffer_addr}, len);
        repeat (3) @(negedge clk);
        #2;
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("done_single", done_cnt - d0, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks", checks);
        $fatal(1);
    end

    initial begin
        int d0, w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_txwr", {31'd0, tx_wr}, 32'd0);
        check("rst_txdata", {24'd0, tx_data}, 32'd0);
        check("rst_addr", {24'd0, buffer_addr}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // len=1, payload 0x01, both dones 20 cycles after each strobe.
        fill_random(0); mem[0] = 8'h01;
        w0 = wr_cnt;
        run_packet(1, 20, 20, 1'b0, 32'h5E);
        check("wr_count_len1", wr_cnt - w0, 32'd4);

        // len=9, "123456789".
        fill_random(0);
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        run_packet(9, 3, 6, 1'b0, 32'hA1);

        // len=0 gives D5 00 00.
        fill_random(0);
        run_packet(0, 2, 2, 1'b0, 32'h00);

        // Skewed acknowledges and an ignored packet_wr while busy.
        fill_random(5);
        run_packet(5, 5, 30, 1'b1, -1);

        // Random packets, including a full 255-byte payload.
        for (int p = 0; p < 3; p++) begin
            int l;
            l = $urandom_range(2, 40);
            fill_random(l);
            run_packet(l, $urandom_range(1, 8), $urandom_range(1, 8), 1'b0, -1);
        end
        fill_random(255);
        run_packet(255, 2, 3, 1'b0, -1);

        // Reset in mid-packet.
        fill_random(6);
        dly1 = 3; dly2 = 4;
        d0 = done_cnt; w0 = wr_cnt;
        start_packet(6);
        for (int c = 0; c < 300 && wr_cnt < w0 + 4; c++) @(negedge clk);
        check("reached_payload", {31'd0, wr_cnt >= w0 + 4}, 32'd1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_txwr", {31'd0, tx_wr}, 32'd0);
        check("arst_addr", {24'd0, buffer_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #2;
        check("no_done_after_rst", done_cnt - d0, 32'd0);
        fill_random(7);
        run_packet(7, 4, 2, 1'b0, -1);

`ifdef S3G_TX_STREAM_TIMEOUT_EN
        // Withheld UART2 completion triggers the watchdog.
        fill_random(3);
        d0 = done_cnt; w0 = err_cnt;
        withhold2 = 1'b1;
        dly1 = 3; dly2 = 3;
        start_packet(3);
        for (int c = 0; c < 400 && err_cnt == w0; c++) @(negedge clk);
        withhold2 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("timeout_error", err_cnt - w0, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_no_done", done_cnt - d0, 32'd0);
        fill_random(4);
        run_packet(4, 2, 5, 1'b0, -1);
        check("error_total", err_cnt, 32'd1);
`else
        check("error_total", err_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
